// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the two-port SPI arbiter/sequencer.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam int ARB_TIMEOUT_DEF = 64;
  localparam int ARB_DATA_W_DEF  = 8;
  localparam int ARB_ADDR_W_DEF  = 8;

endpackage

// File: rtl/spi_arb_if.sv
// Requester handshakes plus the spi_if-facing signals of the arbiter.
interface spi_arb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req0_in, req1_in;
  logic              we0_in, we1_in;
  logic [DATA_W-1:0] wdata0_in, wdata1_in;
  logic              done0_out, done1_out;
  logic              err_out;
  logic [DATA_W-1:0] rdata_out;
  logic [ADDR_W-1:0] raddr_out;
  logic              spi_read_out, spi_send_out;
  logic [DATA_W-1:0] spi_data_out;
  logic              spi_driver_out;
  logic              spi_ready_in;
  logic [DATA_W-1:0] spi_rdata_in;
  logic [ADDR_W-1:0] spi_raddr_in;
  logic              spi_abort_out;

  // master: the arbiter itself; slave: requesters plus spi_if.
  modport master (
    input  req0_in, req1_in, we0_in, we1_in, wdata0_in, wdata1_in,
    input  spi_ready_in, spi_rdata_in, spi_raddr_in,
    output done0_out, done1_out, err_out, rdata_out, raddr_out,
    output spi_read_out, spi_send_out, spi_data_out, spi_driver_out, spi_abort_out
  );

  modport slave (
    output req0_in, req1_in, we0_in, we1_in, wdata0_in, wdata1_in,
    output spi_ready_in, spi_rdata_in, spi_raddr_in,
    input  done0_out, done1_out, err_out, rdata_out, raddr_out,
    input  spi_read_out, spi_send_out, spi_data_out, spi_driver_out, spi_abort_out
  );
endinterface

// File: rtl/spi_arb_rr_pick2.sv
// Two-input round-robin picker: on a tie the port other than `last` wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant_valid,
  output logic grant_idx
);
  assign grant_valid = req0 | req1;
  assign grant_idx   = req1 & (~req0 | ~last);
endmodule

// File: rtl/spi_arb.sv
// Shares spi_if between two requesters: grant, pulse read/send, wait for
// ready or time out (aborting spi_if), then return a one-cycle done.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int DATA_W  = ARB_DATA_W_DEF,
  parameter int ADDR_W  = ARB_ADDR_W_DEF,
  parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  spi_arb_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state, nxt;
  logic              gnt_q, last_q, we_q, err_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pick_valid, pick_idx;
  logic              abort;

  rr_pick2 u_pick (
    .req0        (bus.req0_in),
    .req1        (bus.req1_in),
    .last        (last_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  always_comb begin
    nxt   = state;
    abort = 1'b0;
    unique case (state)
      ARB_IDLE:  if (pick_valid) nxt = ARB_ISSUE;
      ARB_ISSUE: nxt = ARB_WAIT;
      ARB_WAIT: begin
        // ready takes priority over a timeout landing in the same cycle
        if (bus.spi_ready_in) nxt = ARB_DONE;
        else if (cnt_q == CNT_LAST) begin
          abort = 1'b1;
          nxt   = ARB_DONE;
        end
      end
      ARB_DONE:  nxt = ARB_IDLE;
      default:   nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        ARB_IDLE: if (pick_valid) begin
          gnt_q   <= pick_idx;
          we_q    <= pick_idx ? bus.we1_in : bus.we0_in;
          wdata_q <= pick_idx ? bus.wdata1_in : bus.wdata0_in;
        end
        ARB_ISSUE: cnt_q <= '0;
        ARB_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.spi_ready_in) begin
            rdata_q <= bus.spi_rdata_in;
            raddr_q <= bus.spi_raddr_in;
            err_q   <= 1'b0;
          end else if (abort) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ARB_DONE: last_q <= gnt_q;
        default: ;
      endcase
    end
  end

  assign bus.spi_read_out   = (state == ARB_ISSUE) & ~we_q;
  assign bus.spi_send_out   = (state == ARB_ISSUE) &  we_q;
  assign bus.spi_data_out   = wdata_q;
  assign bus.spi_driver_out = (state != ARB_IDLE) & gnt_q;
  assign bus.spi_abort_out  = abort;
  assign bus.done0_out      = (state == ARB_DONE) & ~gnt_q;
  assign bus.done1_out      = (state == ARB_DONE) &  gnt_q;
  assign bus.err_out        = (state == ARB_DONE) &  err_q;
  assign bus.rdata_out      = rdata_q;
  assign bus.raddr_out      = raddr_q;

endmodule

// File: doc/spi_arb.md
# spi_arb

Two-port arbiter and transaction sequencer in front of the single `spi_if` instance. It shares the SPI read/send interface between the core's load/store unit (port 0) and the boot/debug loader (port 1). It turns each granted request into the one-cycle `read_in`/`send_in` pulse that `spi_if` expects, and waits for `ready_out`. It returns data to the granted port, or reports an error and resets `spi_if` if the transfer stalls.

## Interface
- `DATA_W`, `` `DATAPATH_W ``, data width of requests and of `spi_if`.
- `ADDR_W`, `` `CLOG2(`DMEM_SZ) ``, address field width returned by `spi_if` in driver mode.
- `TIMEOUT`, 64, maximum cycles in WAIT before abort; legal range 16..255.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_in`, `req1_in`  in  1 each  request level; held until the matching done pulse.
- `we0_in`, `we1_in`  in  1 each  1 = send (write), 0 = read; valid while req is high.
- `wdata0_in`, `wdata1_in`  in  DATA_W each  send data; valid while req is high.
- `done0_out`, `done1_out`  out  1 each  one-cycle completion pulse to the granted port.
- `err_out`  out  1  high together with a done pulse when the transaction timed out.
- `rdata_out`  out  DATA_W  read data, shared by both ports; valid in the done cycle and held until the next done.
- `raddr_out`  out  ADDR_W  `spi_if` `addr_out` captured at ready; meaningful for port 1 only.
- `spi_read_out`, `spi_send_out`  out  1  one-cycle pulses to `spi_if` `read_in`/`send_in`.
- `spi_data_out`  out  DATA_W  to `spi_if` `data_in`; valid in the pulse cycle.
- `spi_driver_out`  out  1  to `spi_if` `driver_io_in`; 1 while port 1 is granted.
- `spi_ready_in`  in  1  from `spi_if` `ready_out`.
- `spi_rdata_in`  in  DATA_W  from `spi_if` `data_out`.
- `spi_raddr_in`  in  ADDR_W  from `spi_if` `addr_out`.
- `spi_abort_out`  out  1  one-cycle pulse, ORed by the parent into `spi_if` reset.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If any req is high: grant, latch `we` and `wdata` of the winner, and go to ISSUE.
  - Otherwise stay in IDLE.
- **Arbitration** is round-robin via a `last` bit.
  - If both requests are high, the port ≠ `last` wins.
  - If only one is high, it wins regardless of `last`.
  - `last` updates to the granted port in DONE.
- **ISSUE** lasts exactly one cycle.
  - Assert `spi_send_out` if the latched `we` = 1, else `spi_read_out`.
  - `spi_data_out` = latched wdata.
  - Clear the timeout counter. Go to WAIT.
- **WAIT**
  - The counter increments each cycle.
  - If `spi_ready_in` is high: capture `spi_rdata_in` and `spi_raddr_in`, clear the error flag, and go to DONE.
  - Else, if the counter reaches `TIMEOUT - 1`: set rdata to 0, set the error flag, pulse `spi_abort_out` this cycle, and go to DONE.
  - If ready and timeout occur in the same cycle, ready wins: no error, no abort.
- **DONE** lasts exactly one cycle.
  - Pulse `done<g>_out`; `err_out` equals the error flag.
  - Go to IDLE.
- `spi_driver_out` equals the grant bit (1 for port 1) during ISSUE, WAIT and DONE, and is 0 in IDLE.
- A req that drops before its done pulse is a protocol violation. The transaction still completes and the done pulse is still issued.
- `wdata`/`we` changes after grant are ignored, because the values were latched in IDLE.

## Timing
- Reset values: state = IDLE, `last` = 1 (so port 0 wins the first tie), all pulse outputs 0, `rdata_out` = 0, `raddr_out` = 0, `spi_driver_out` = 0, counter = 0.
- Latency from req high in IDLE to the `spi_*` pulse is 1 cycle.
- Latency from `spi_ready_in` to done is 1 cycle.
- Minimum req-to-done latency is 3 cycles plus `spi_if` transfer time.
- After done, the block returns to IDLE and can grant again on the next cycle, giving 1 idle cycle between back-to-back transactions.
- A requester must deassert req in the cycle after its done pulse, or it re-enters arbitration.
- Timeout asserts at WAIT cycle `TIMEOUT`; done/err follow 1 cycle later.
- Asynchronous reset mid-transaction returns to IDLE immediately.
  - No done pulse is generated.
  - `spi_abort_out` is not asserted; `spi_if` shares the same reset.

## Structure
- Add to `defs.vh`: state encodings `ARB_IDLE`/`ARB_ISSUE`/`ARB_WAIT`/`ARB_DONE` and `` `ARB_TIMEOUT_DEF ``.
- Counter width is `` `CLOG2(TIMEOUT) ``.
- One natural sub-module: `rr_pick2`, a combinational two-input round-robin picker taking req0, req1 and last and returning grant_valid and grant_idx.
- Everything else stays flat.

## Test plan
- **Reset:** assert `rst` = 0, then release -> all outputs 0, state IDLE.
- **Single read, port 0:** `spi_ready_in` returned 10 cycles after the pulse with `spi_rdata_in` = 8'hA5 -> `spi_read_out` 1 cycle after req, `done0_out` one cycle after ready, `rdata_out` = 8'hA5, `err_out` = 0, `spi_driver_out` = 0 throughout.
- **Contention:** req0 and req1 both high and held -> grants go 0,1,0,1; `spi_driver_out` = 1 only during port-1 transactions; `raddr_out` is captured on port-1 done.
- **Send, port 1:** `we1_in` = 1, `wdata1_in` = 8'h3C -> `spi_send_out` pulse with `spi_data_out` = 8'h3C in the same cycle.
- **Timeout:** no `spi_ready_in` -> `spi_abort_out` at WAIT cycle 64, then done with `err_out` = 1 and `rdata_out` = 0. Repeat with ready arriving exactly at cycle 64 -> no error, no abort.
- **Mid-WAIT reset:** reset asserted during WAIT -> immediate IDLE, no done pulse; a new request after release completes normally.
